// File: rtl/rom_loader.sv
// Program-memory loader: assembles a little-endian byte stream into words and
// writes them to consecutive word addresses. Optional checksum word: ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic [15:0]      load_words,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_wen,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       dbg_state
);

  // Byte handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_byte_cnt;
  logic [15:0]      r_word_cnt;
  logic [15:0]      r_load_words;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_done;
  logic             r_error;

  state_t           w_state_nxt;
  logic [1:0]       w_byte_cnt_nxt;
  logic [15:0]      w_word_cnt_nxt;
  logic [15:0]      w_load_words_nxt;
  logic [WIDTH-1:0] w_addr_nxt;
  logic [WIDTH-1:0] w_wdata_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;

  logic             w_start_ok;
  logic             w_lw_bad;
  logic             w_xfer;
  logic [15:0]      w_word_cnt_inc;
  logic             w_last_word;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] r_sum;
  logic             r_ck_phase;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_ck_phase_nxt;
  logic [WIDTH-1:0] w_ck_word;
`endif

  assign w_start_ok     = start && ((r_state == S_IDLE) || (r_state == S_FINISH));
  assign w_lw_bad       = (load_words == 16'd0) || ({16'd0, load_words} > 32'(DEPTH));
  assign w_xfer         = in_valid && (r_state == S_COLLECT);
  assign w_word_cnt_inc = r_word_cnt + 16'd1;
  assign w_last_word    = (w_word_cnt_inc == r_load_words);

`ifdef ROM_LOADER_CHECKSUM_EN
  // The checksum word completes on its 4th byte; compare it without registering it.
  assign w_ck_word = WIDTH'({in_data, r_wdata[23:0]});
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_word_cnt_nxt   = r_word_cnt;
    w_load_words_nxt = r_load_words;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_done_nxt       = r_done;
    w_error_nxt      = r_error;
`ifdef ROM_LOADER_CHECKSUM_EN
    w_sum_nxt        = r_sum;
    w_ck_phase_nxt   = r_ck_phase;
`endif
    case (r_state)
      S_IDLE, S_FINISH: begin
        if (w_start_ok) begin
          w_done_nxt       = 1'b0;
          w_error_nxt      = 1'b0;
          w_addr_nxt       = '0;
          w_byte_cnt_nxt   = 2'd0;
          w_word_cnt_nxt   = 16'd0;
          w_load_words_nxt = load_words;
`ifdef ROM_LOADER_CHECKSUM_EN
          w_sum_nxt        = '0;
          w_ck_phase_nxt   = 1'b0;
`endif
          if (w_lw_bad) begin
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
            w_error_nxt = 1'b1;
          end else begin
            w_state_nxt = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (w_xfer) begin
          case (r_byte_cnt)
            2'd0:    w_wdata_nxt[7:0]   = in_data;
            2'd1:    w_wdata_nxt[15:8]  = in_data;
            2'd2:    w_wdata_nxt[23:16] = in_data;
            default: w_wdata_nxt[31:24] = in_data;
          endcase
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            if (r_ck_phase) begin
              w_state_nxt = S_FINISH;
              w_done_nxt  = 1'b1;
              w_error_nxt = (w_ck_word != r_sum);
            end else begin
              w_state_nxt = S_WRITE;
            end
`else
            w_state_nxt = S_WRITE;
`endif
          end
        end
      end
      S_WRITE: begin
        w_addr_nxt     = r_addr + WIDTH'(4);
        w_word_cnt_nxt = w_word_cnt_inc;
`ifdef ROM_LOADER_CHECKSUM_EN
        w_sum_nxt      = r_sum + r_wdata;
        w_state_nxt    = S_COLLECT;
        if (w_last_word) begin
          w_ck_phase_nxt = 1'b1;
        end
`else
        if (w_last_word) begin
          w_state_nxt = S_FINISH;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_COLLECT;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_word_cnt   <= 16'd0;
      r_load_words <= 16'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
      r_ck_phase   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_load_words <= w_load_words_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum        <= w_sum_nxt;
      r_ck_phase   <= w_ck_phase_nxt;
`endif
    end
  end

  assign in_ready    = (r_state == S_COLLECT);
  assign mem_wen     = (r_state == S_WRITE);
  assign busy        = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;
  assign done        = r_done;
  assign error       = r_error;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table of load scenarios, scoreboard of
// expected {address, data} writes, plus hand-written reset and idle sequences.
module tb_rom_loader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2048;

  logic             clock = 1'b0;
  logic             nreset = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      load_words = 16'd0;
  logic [7:0]       in_data = 8'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mem_wen;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       dbg_state;

  rom_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .nreset(nreset), .start(start), .load_words(load_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_wen(mem_wen), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    int lw;
    int pat;       // 0 random words, 1 12345678/DEADBEEF, 2 words 1,2
    bit toggle;
    bit inject;
    bit bad_ck;
    bit exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every write strobe pops one expected {address, data}
  logic [63:0] mon_e;
  logic        mon_prev_wen = 1'b0;
  always @(negedge clock) begin
    if (nreset && mem_wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_address, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr_data", {mem_address, mem_wdata}, mon_e);
      end
      if (mon_prev_wen) check("wen_single_cycle", 64'(mon_prev_wen), 64'd0);
    end
    mon_prev_wen = nreset && mem_wen;
  end

  // driver: tasks start and end 1 time unit after a rising edge
  task automatic run_load(input int vi, input vec_t v);
    logic [7:0]  b[$];
    logic [31:0] w, sum;
    int n, idx, cyc, iter, exp_cyc;
    bit acc;
    sum = 32'd0;
    n = (v.lw >= 1 && v.lw <= DEPTH) ? v.lw : 0;
    for (int wi = 0; wi < n; wi++) begin
      if (v.pat == 1) w = (wi == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF;
      else if (v.pat == 2) w = 32'(wi + 1);
      else w = $urandom;
      for (int k = 0; k < 4; k++) b.push_back(w[8*k +: 8]);
      exp_q.push_back({32'(wi * 4), w});
      sum = sum + w;
    end
    exp_cyc = 5 * n;
`ifdef ROM_LOADER_CHECKSUM_EN
    if (n > 0) begin
      w = sum + (v.bad_ck ? 32'd1 : 32'd0);
      for (int k = 0; k < 4; k++) b.push_back(w[8*k +: 8]);
      exp_cyc = exp_cyc + 4;
    end
`endif
    start = 1'b1;
    load_words = 16'(v.lw);
    @(posedge clock); #1;
    start = 1'b0;
    if (n == 0) begin
      check($sformatf("v%0d_rej_done", vi), 64'(done), 64'd1);
      check($sformatf("v%0d_rej_error", vi), 64'(error), 64'd1);
      check($sformatf("v%0d_rej_busy", vi), 64'(busy), 64'd0);
      @(posedge clock); #1;
      check($sformatf("v%0d_rej_hold", vi), 64'({done, error, busy}), 64'b110);
      return;
    end
    check($sformatf("v%0d_start_flags", vi), 64'({busy, done, error}), 64'b100);
    idx = 0;
    iter = 0;
    cyc = 0;
    while (idx < b.size() && iter < 400) begin
      in_valid = v.toggle ? (iter % 2 == 0) : 1'b1;
      in_data = b[idx];
      if (v.inject && iter == 2) begin
        start = 1'b1;
        load_words = 16'd0;
      end
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
      iter++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    if (idx < b.size()) check($sformatf("v%0d_byte_timeout", vi), 64'(idx), 64'(b.size()));
    while (!done && cyc < 12 * v.lw + 60) begin
      @(posedge clock); #1;
      cyc++;
    end
    check($sformatf("v%0d_done", vi), 64'(done), 64'd1);
    check($sformatf("v%0d_error", vi), 64'(error), 64'(v.exp_err));
    check($sformatf("v%0d_busy", vi), 64'(busy), 64'd0);
    check($sformatf("v%0d_writes_left", vi), 64'(exp_q.size()), 64'd0);
    if (!v.toggle) check($sformatf("v%0d_cycles", vi), 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {58'd0, in_ready, mem_wen, busy, done, error, 1'b0}, 64'd0);
    check({name, "_addr_data"}, {mem_address, mem_wdata}, 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    #2 check_all_zero("reset");
    @(posedge clock); #1;
    nreset = 1'b1;

    // bytes offered in IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'hAA;
      check("idle_in_ready", 64'(in_ready), 64'd0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;

    vecs.push_back('{lw: 2,    pat: 1, toggle: 0, inject: 0, bad_ck: 0, exp_err: 0});
    vecs.push_back('{lw: 0,    pat: 0, toggle: 0, inject: 0, bad_ck: 0, exp_err: 1});
    vecs.push_back('{lw: 2049, pat: 0, toggle: 0, inject: 0, bad_ck: 0, exp_err: 1});
    vecs.push_back('{lw: 1,    pat: 0, toggle: 1, inject: 0, bad_ck: 0, exp_err: 0});
    vecs.push_back('{lw: 3,    pat: 0, toggle: 0, inject: 1, bad_ck: 0, exp_err: 0});
    vecs.push_back('{lw: 4,    pat: 0, toggle: 0, inject: 0, bad_ck: 0, exp_err: 0});
    vecs.push_back('{lw: 3,    pat: 0, toggle: 1, inject: 1, bad_ck: 0, exp_err: 0});
`ifdef ROM_LOADER_CHECKSUM_EN
    vecs.push_back('{lw: 2,    pat: 2, toggle: 0, inject: 0, bad_ck: 0, exp_err: 0});
    vecs.push_back('{lw: 2,    pat: 2, toggle: 0, inject: 0, bad_ck: 1, exp_err: 1});
`endif
    for (int i = 0; i < vecs.size(); i++) run_load(i, vecs[i]);

    // reset in the middle of word 1: partial word dropped, no write
    start = 1'b1;
    load_words = 16'd1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h11 * (i + 1));
      @(posedge clock); #1;
    end
    check("pre_reset_busy", 64'(busy), 64'd1);
    nreset = 1'b0;
    #1 check_all_zero("midload_reset");
    in_valid = 1'b0;
    @(posedge clock); #1;
    check_all_zero("midload_reset_held");
    nreset = 1'b1;
    run_load(100, '{lw: 1, pat: 0, toggle: 0, inject: 0, bad_ck: 0, exp_err: 0});

    repeat (3) @(posedge clock);
    #1 check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 2048, giving the program memory capacity in words.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle load request.
REQ-006 SHALL have port load_words  input  16  number of words to load, sampled when start is accepted.
REQ-007 SHALL have port in_data  input  8  incoming program byte.
REQ-008 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-009 SHALL have port in_ready  output  1  the loader accepts a byte this cycle.
REQ-010 SHALL have port mem_wen  output  1  program memory word write strobe.
REQ-011 SHALL have port mem_address  output  WIDTH  byte address of the word being written; always a multiple of 4.
REQ-012 SHALL have port mem_wdata  output  WIDTH  assembled word.
REQ-013 SHALL have port busy  output  1  load in progress; also used to hold the CPU in reset.
REQ-014 SHALL have port done  output  1  sticky; the last load finished.
REQ-015 SHALL have port error  output  1  sticky; the last load was rejected or failed.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE and FINISH.
REQ-017 start SHALL be accepted only in IDLE or FINISH; accepting it clears done and error, sets mem_address to 0 and clears the byte and word counters.
REQ-018 start with load_words==0 or load_words>DEPTH SHALL go to FINISH with error=1, done=1 and no memory write.
REQ-019 start with a valid load_words SHALL go to COLLECT.
REQ-020 start SHALL be ignored in COLLECT and WRITE.
REQ-021 in_ready SHALL be 1 only in COLLECT.
REQ-022 A byte transfers when in_valid and in_ready are both 1; in_valid without in_ready SHALL have no effect.
REQ-023 Bytes SHALL pack little-endian: the 1st byte to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-024 After the 4th byte transfers, the state SHALL be WRITE on the next cycle.
REQ-025 WRITE SHALL last exactly 1 cycle, with mem_wen=1 and mem_wdata/mem_address stable.
REQ-026 mem_wen SHALL be 0 in every other state.
REQ-027 On leaving WRITE, mem_address SHALL increase by 4, modulo 2^WIDTH, and the word counter by 1.
REQ-028 On leaving WRITE, if the word counter equals load_words the state SHALL go to FINISH with done=1; otherwise it SHALL return to COLLECT.
REQ-029 Peak throughput SHALL be 4 bytes per 5 cycles.
REQ-030 busy SHALL be 1 in COLLECT and WRITE, and 0 in IDLE and FINISH.
REQ-031 FINISH SHALL hold done and error until the next accepted start.

Reset
REQ-032 nreset low SHALL immediately force: IDLE, all counters 0, in_ready=0, mem_wen=0, mem_address=0, mem_wdata=0, busy=0, done=0, error=0.
REQ-033 A reset mid-load SHALL abandon the partial word with no further write; the words already written are not rolled back.

Configuration
REQ-034 With macro ROM_LOADER_CHECKSUM_EN defined:
- a WIDTH-bit running sum (modulo 2^WIDTH) SHALL accumulate every written word;
- after the last word, one extra little-endian word SHALL be collected and not written (mem_wen stays 0);
- FINISH is then entered with done=1, and error=1 if that word differs from the sum.
REQ-035 Without ROM_LOADER_CHECKSUM_EN, no checksum word SHALL be expected and no sum logic SHALL exist.

Verification
REQ-036 start, load_words=2, bytes 78 56 34 12 EF BE AD DE:
- writes 0x12345678 @0 and 0xDEADBEEF @4;
- then done=1, error=0, busy=0.
REQ-037 start, load_words=0 -> next cycle done=1, error=1, no mem_wen; start, load_words=2049 -> same.
REQ-038 in_valid toggled 1/0 each cycle during load_words=1 -> single write of the correct word; bytes are accepted only while in_ready=1.
REQ-039 nreset asserted after 2 bytes of word 1 -> all outputs 0 while reset is low; a new start, load_words=1 -> write @0.
REQ-040 start pulsed during COLLECT -> ignored; the address sequence and done timing are unchanged.
REQ-041 With ROM_LOADER_CHECKSUM_EN: words 1, 2 then checksum 3 -> error=0; checksum 4 -> error=1; in both cases exactly 2 writes.
